// File: rtl/i2c_txn_sequencer.sv
// Whole-transaction front end for the byte-level I2C master: address phase, 1-4 data
// bytes, stop, then a single response pulse carrying read data and an error flag.
module i2c_txn_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [6:0]  i_cmd_addr,
  input  logic        i_cmd_rw,
  input  logic [2:0]  i_cmd_len,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_resp_valid,
  output logic        o_resp_error,
  output logic [31:0] o_resp_rdata,
  output logic        o_busy,
  output logic        o_i2c_start,
  output logic        o_i2c_stop,
  output logic        o_i2c_en,
  output logic [7:0]  o_tx_data,
  input  logic        i_ready,
  input  logic        i_tx_done,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_ADDR, S_WR_BYTE, S_WAIT_TX,
    S_RD_BYTE, S_WAIT_RX, S_STOP, S_WAIT_STOP, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_addr;
  logic        r_rw;
  logic [2:0]  r_len;
  logic [31:0] r_wdata;
  logic [2:0]  r_idx, w_idx;
  logic [CW-1:0] r_tmo_cnt;
  logic        r_err, w_err;
  logic [31:0] r_rdata, w_rdata;
  logic        r_start, w_start, r_stop, w_stop, r_en, w_en, r_resp_valid, w_resp_valid;
  logic [7:0]  r_tx_data, w_tx_data;
  logic        w_accept, w_in_wait, w_tmo_hit;
  logic [2:0]  w_idx_inc;

  assign w_accept  = (r_state == S_IDLE) && i_cmd_valid;
  assign w_in_wait = r_state inside {S_START, S_WAIT_ADDR, S_WAIT_TX, S_WAIT_RX, S_WAIT_STOP};
  // Fires on the cycle the counter would step onto TIMEOUT_CYCLES-1, so the error and
  // the exit transition register together with that count.
  assign w_tmo_hit = w_in_wait && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 2));
  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx        = r_idx;
    w_err        = r_err;
    w_rdata      = r_rdata;
    w_tx_data    = r_tx_data;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_en         = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_idx   = 3'd0;
          w_rdata = 32'd0;
          w_err   = (i_cmd_len == 3'd0) || (i_cmd_len > 3'd4);
          w_state_nxt = w_err ? S_DONE : S_START;
        end
      end
      S_START: begin
        if (i_ready) begin
          w_start     = 1'b1;
          w_en        = 1'b1;
          w_tx_data   = {r_addr, r_rw};
          w_state_nxt = S_WAIT_ADDR;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_ADDR: begin
        if (i_tx_done) begin
          w_state_nxt = r_rw ? S_RD_BYTE : S_WR_BYTE;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_WR_BYTE: begin
        w_tx_data   = r_wdata[{r_idx[1:0], 3'b000} +: 8];
        w_en        = 1'b1;
        w_state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          w_idx       = w_idx_inc;
          w_state_nxt = (w_idx_inc == r_len) ? S_STOP : S_WR_BYTE;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_RD_BYTE: begin
        w_en        = 1'b1;
        w_state_nxt = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (i_rx_done) begin
          w_rdata[{r_idx[1:0], 3'b000} +: 8] = i_rx_data;
          w_idx       = w_idx_inc;
          w_state_nxt = (w_idx_inc == r_len) ? S_STOP : S_RD_BYTE;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_stop      = 1'b1;
        w_en        = 1'b1;
        w_state_nxt = S_WAIT_STOP;
      end
      S_WAIT_STOP: begin
        if (i_ready) begin
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_resp_valid = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr       <= 7'd0;
      r_rw         <= 1'b0;
      r_len        <= 3'd0;
      r_wdata      <= 32'd0;
      r_idx        <= 3'd0;
      r_tmo_cnt    <= '0;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_en         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_tx_data    <= 8'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_cmd_addr;
        r_rw    <= i_cmd_rw;
        r_len   <= i_cmd_len;
        r_wdata <= i_cmd_wdata;
      end
      // No state loops on itself through a transition, so any change is a wait entry reset.
      if (w_state_nxt != r_state) r_tmo_cnt <= '0;
      else if (w_in_wait)         r_tmo_cnt <= r_tmo_cnt + CW'(1);
      r_idx        <= w_idx;
      r_err        <= w_err;
      r_rdata      <= w_rdata;
      r_start      <= w_start;
      r_stop       <= w_stop;
      r_en         <= w_en;
      r_resp_valid <= w_resp_valid;
      r_tx_data    <= w_tx_data;
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_error = r_err;
  assign o_resp_rdata = r_rdata;
  assign o_i2c_start  = r_start;
  assign o_i2c_stop   = r_stop;
  assign o_i2c_en     = r_en;
  assign o_tx_data    = r_tx_data;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: a vector table of whole transactions run against
// a small byte-level master model, plus hand sequences for timeout, reset and back-to-back.
module tb_i2c_txn_sequencer;

  localparam int TMO = 64;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [6:0]  i_cmd_addr = 7'd0;
  logic        i_cmd_rw = 1'b0;
  logic [2:0]  i_cmd_len = 3'd0;
  logic [31:0] i_cmd_wdata = 32'd0;
  logic        i_ready = 1'b1;
  logic        i_tx_done = 1'b0;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        o_cmd_ready, o_resp_valid, o_resp_error, o_busy;
  logic        o_i2c_start, o_i2c_stop, o_i2c_en;
  logic [31:0] o_resp_rdata;
  logic [7:0]  o_tx_data;

  i2c_txn_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
    .i_cmd_wdata(i_cmd_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_error(o_resp_error), .o_resp_rdata(o_resp_rdata),
    .o_busy(o_busy),
    .o_i2c_start(o_i2c_start), .o_i2c_stop(o_i2c_stop), .o_i2c_en(o_i2c_en),
    .o_tx_data(o_tx_data),
    .i_ready(i_ready), .i_tx_done(i_tx_done), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit        rw;
    bit [6:0]  addr;
    bit [2:0]  len;
    bit [31:0] wdata;
    bit [31:0] rbytes;
    int        exp_ntx;
    bit [39:0] exp_tx;
    bit [31:0] exp_rdata;
    bit        exp_err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int nstart, nstop, nen, ntx, nacc, c_acc, c_start, c_stop, c_resp;
  bit [7:0]    tx_log [8];
  logic [31:0] got_rdata;
  logic        got_err;
  bit          got_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ready_busy"}, 64'({o_cmd_ready, o_busy}), 64'(2'b10));
    chk({name, "_strobes"}, 64'({o_i2c_start, o_i2c_stop, o_i2c_en, o_resp_valid, o_resp_error}), 64'd0);
    chk({name, "_tx_data"}, 64'(o_tx_data), 64'd0);
    chk({name, "_rdata"}, 64'(o_resp_rdata), 64'd0);
  endtask

  // Called at a negedge; presents the command and plays the master until resp_valid.
  task automatic run_txn(input vec_t v, input bit hold, input bit withhold, input bit stray,
                         input int rst_at_en);
    int tx_cnt, rx_cnt, rx_k, rdy_hold;
    bit acc_pend;
    bit [31:0] rb;
    tx_cnt = 0; rx_cnt = 0; rx_k = 0; rdy_hold = 0; acc_pend = 0; rb = v.rbytes;
    nstart = 0; nstop = 0; nen = 0; ntx = 0; nacc = 0;
    c_acc = -1000; c_start = -1000; c_stop = -1000; c_resp = -1000;
    got_resp = 0; got_rdata = 32'hx; got_err = 1'bx;
    i_cmd_valid = 1'b1; i_cmd_addr = v.addr; i_cmd_rw = v.rw;
    i_cmd_len = v.len; i_cmd_wdata = v.wdata;
    for (int t = 0; t < 400; t++) begin
      if (i_cmd_valid && o_cmd_ready) begin
        nacc++;
        if (nacc == 1) c_acc = cyc;
        acc_pend = 1;
      end
      @(negedge i_clk);
      if (acc_pend && !hold) i_cmd_valid = 1'b0;
      acc_pend = 0;
      if (o_i2c_start) begin nstart++; c_start = cyc; end
      if (o_i2c_stop) begin nstop++; c_stop = cyc; rdy_hold = 3; end
      if (o_i2c_en) begin
        nen++;
        if (o_i2c_start) begin
          if (ntx < 8) tx_log[ntx] = o_tx_data;
          ntx++;
          tx_cnt = withhold ? 0 : 2;
        end else if (!o_i2c_stop) begin
          if (v.rw) rx_cnt = 2;
          else begin
            if (ntx < 8) tx_log[ntx] = o_tx_data;
            ntx++;
            tx_cnt = 2;
          end
        end
        if (rst_at_en != 0 && nen == rst_at_en) begin
          i_rst_n = 1'b0;
          i_cmd_valid = 1'b0; i_tx_done = 1'b0; i_rx_done = 1'b0; i_ready = 1'b1;
          #1;
          check_idle("midreset");
          @(negedge i_clk);
          i_rst_n = 1'b1;
          return;
        end
      end
      if (o_resp_valid) begin
        got_resp = 1; got_rdata = o_resp_rdata; got_err = o_resp_error; c_resp = cyc;
        i_tx_done = 1'b0; i_rx_done = 1'b0; i_ready = 1'b1;
        break;
      end
      i_tx_done = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) i_tx_done = 1'b1;
        if (stray) begin i_rx_done = 1'b1; i_rx_data = 8'hEE; end
      end
      if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0) begin
          i_rx_done = 1'b1;
          i_rx_data = rb[8*rx_k +: 8];
          rx_k++;
        end
      end
      if (rdy_hold > 0) begin rdy_hold--; i_ready = 1'b0; end
      else i_ready = 1'b1;
    end
  endtask

  task automatic check_txn(input vec_t v, input string n);
    bit legal;
    bit [39:0] et;
    legal = (v.len >= 3'd1) && (v.len <= 3'd4);
    et = v.exp_tx;
    chk({n, "_resp_seen"}, 64'(got_resp), 64'd1);
    chk({n, "_ntx"}, 64'(ntx), 64'(v.exp_ntx));
    for (int k = 0; k < v.exp_ntx && k < 8; k++)
      chk($sformatf("%s_tx%0d", n, k), 64'(tx_log[k]), 64'(et[8*k +: 8]));
    chk({n, "_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
    chk({n, "_err"}, 64'(got_err), 64'(v.exp_err));
    chk({n, "_nstart"}, 64'(nstart), legal ? 64'd1 : 64'd0);
    chk({n, "_nstop"}, 64'(nstop), legal ? 64'd1 : 64'd0);
    chk({n, "_nen"}, 64'(nen), legal ? 64'(v.len + 2) : 64'd0);
    if (legal) chk({n, "_start_lat"}, 64'(c_start - c_acc), 64'd2);
    else       chk({n, "_resp_lat"}, 64'(c_resp - c_acc), 64'd2);
  endtask

  vec_t vecs [8];
  vec_t vt;
  int   prev_resp;

  initial begin
    //            rw addr   len  wdata         rbytes        ntx exp_tx            exp_rdata     err
    vecs[0] = '{1'b0, 7'h28, 3'd2, 32'h0000_A55A, 32'h0,        3, 40'h00_00_A5_5A_50, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 7'h28, 3'd4, 32'h0,        32'h4433_2211, 1, 40'h51,             32'h4433_2211, 1'b0};
    vecs[2] = '{1'b0, 7'h28, 3'd0, 32'h1234_5678, 32'h0,        0, 40'h0,              32'h0,        1'b1};
    vecs[3] = '{1'b1, 7'h28, 3'd5, 32'h0,        32'h0,        0, 40'h0,              32'h0,        1'b1};
    vecs[4] = '{1'b0, 7'h7F, 3'd4, 32'hDEAD_BEEF, 32'h0,        5, 40'hDE_AD_BE_EF_FE, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 7'h01, 3'd1, 32'h0,        32'h1234_56C3, 1, 40'h03,             32'h0000_00C3, 1'b0};
    vecs[6] = '{1'b1, 7'h55, 3'd3, 32'h0,        32'hFF99_8877, 1, 40'hAB,             32'h0099_8877, 1'b0};
    vecs[7] = '{1'b0, 7'h10, 3'd7, 32'h0,        32'h0,        0, 40'h0,              32'h0,        1'b1};

    repeat (3) @(negedge i_clk);
    check_idle("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], 1'b0, 1'b0, 1'b0, 0);
      check_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Address byte never acknowledged: stop must follow the start by exactly TMO cycles.
    vt = '{1'b0, 7'h28, 3'd1, 32'h0000_0077, 32'h0, 1, 40'h50, 32'h0, 1'b1};
    run_txn(vt, 1'b0, 1'b1, 1'b0, 0);
    chk("tmo_resp_seen", 64'(got_resp), 64'd1);
    chk("tmo_err", 64'(got_err), 64'd1);
    chk("tmo_stop_delay", 64'(c_stop - c_start), 64'(TMO));
    chk("tmo_nstop", 64'(nstop), 64'd1);
    chk("tmo_ntx", 64'(ntx), 64'd1);
    chk("tmo_tx0", 64'(tx_log[0]), 64'h50);

    // Reset lands in WAIT_RX after one read byte was already captured.
    vt = '{1'b1, 7'h28, 3'd3, 32'h0, 32'h0033_2211, 1, 40'h51, 32'h0, 1'b0};
    run_txn(vt, 1'b0, 1'b0, 1'b0, 3);
    chk("midreset_no_resp", 64'(got_resp), 64'd0);
    vt = '{1'b1, 7'h28, 3'd1, 32'h0, 32'hAAAA_AA5C, 1, 40'h51, 32'h0000_005C, 1'b0};
    run_txn(vt, 1'b0, 1'b0, 1'b0, 0);
    check_txn(vt, "after_reset");
    chk("after_reset_upper_zero", 64'(got_rdata[31:8]), 64'd0);

    // cmd_valid held across two identical writes, with stray rx_done pulses in the waits.
    vt = '{1'b0, 7'h3C, 3'd3, 32'h00C0_FFEE, 32'h0, 4, 40'h00_C0_FF_EE_78, 32'h0, 1'b0};
    run_txn(vt, 1'b1, 1'b0, 1'b1, 0);
    check_txn(vt, "b2b_first");
    chk("b2b_first_nacc", 64'(nacc), 64'd1);
    prev_resp = c_resp;
    run_txn(vt, 1'b0, 1'b0, 1'b1, 0);
    check_txn(vt, "b2b_second");
    chk("b2b_second_nacc", 64'(nacc), 64'd1);
    chk("b2b_accept_after_resp", 64'(c_acc >= prev_resp), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
